// File: rtl/cnn_obi_mem_sbr_if.sv
// OBI request/response bundle between the accelerator manager and the word memory.
// Manager drives the A-channel; subordinate drives gnt and the R-channel.
interface cnn_obi_mem_sbr_if #(
    parameter int unsigned IdWidth = 4
);
    logic               req;
    logic               gnt;
    logic [31:0]        addr;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [IdWidth-1:0] aid;
    logic               rvalid;
    logic [31:0]        rdata;
    logic [IdWidth-1:0] rid;
    logic               err;

    modport master (
        output req, addr, we, be, wdata, aid,
        input  gnt, rvalid, rdata, rid, err
    );

    modport slave (
        input  req, addr, we, be, wdata, aid,
        output gnt, rvalid, rdata, rid, err
    );
endinterface

// File: rtl/cnn_obi_mem_sbr.sv
// OBI word memory with side load port; responses Latency cycles after accept, never stalled.
// Backpressure: gnt drops whenever the load port is active; refused cycles are counted.
module cnn_obi_mem_sbr #(
    parameter int unsigned          NumWords = 1024,
    parameter logic [31:0]          BaseAddr = 32'h1A10_0000,
    parameter int unsigned          Latency  = 1,
    parameter int unsigned          IdWidth  = 4,
    localparam int unsigned         IdxW     = $clog2(NumWords)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cnn_obi_mem_sbr_if.slave    obi,
    input  logic                ld_req_i,
    input  logic                ld_we_i,
    input  logic [IdxW-1:0]     ld_idx_i,
    input  logic [31:0]         ld_wdata_i,
    output logic [31:0]         ld_rdata_o,
    output logic                ld_rvalid_o,
    output logic [15:0]         stall_cnt_o
);
    localparam logic [32:0] Span   = 33'(NumWords) << 2;
    localparam logic [31:0] ErrDat = 32'hBADC_AB1E;

    logic [31:0]        mem [NumWords];

    logic               acc;
    logic [31:0]        off;
    logic               in_range;
    logic [IdxW-1:0]    idx;
    logic [31:0]        rsp_dat;

    logic               pipe_vld [Latency];
    logic [IdWidth-1:0] pipe_id  [Latency];
    logic               pipe_err [Latency];
    logic [31:0]        pipe_dat [Latency];

    assign obi.gnt  = obi.req & ~ld_req_i;
    assign acc      = obi.req & obi.gnt;
    assign off      = obi.addr - BaseAddr;
    assign in_range = (obi.addr >= BaseAddr) && ({1'b0, off} < Span);
    assign idx      = off[2 +: IdxW];

    // Read data is sampled before this edge's write, but OBI never accepts a read and write together.
    assign rsp_dat  = !in_range ? ErrDat : (obi.we ? 32'h0 : mem[idx]);

    always_ff @(posedge clk_i) begin
        if (ld_req_i && ld_we_i) begin
            mem[ld_idx_i] <= ld_wdata_i;
        end else if (acc && obi.we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (obi.be[b]) begin
                    mem[idx][8*b +: 8] <= obi.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < Latency; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_id[k]  <= '0;
                pipe_err[k] <= 1'b0;
                pipe_dat[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= acc;
            pipe_id[0]  <= obi.aid;
            pipe_err[0] <= ~in_range;
            pipe_dat[0] <= rsp_dat;
            for (int k = 1; k < Latency; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
                pipe_err[k] <= pipe_err[k-1];
                pipe_dat[k] <= pipe_dat[k-1];
            end
        end
    end

    assign obi.rvalid = pipe_vld[Latency-1];
    assign obi.rid    = pipe_id[Latency-1];
    assign obi.err    = pipe_err[Latency-1];
    assign obi.rdata  = pipe_dat[Latency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_rvalid_o <= 1'b0;
            ld_rdata_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            ld_rvalid_o <= ld_req_i & ~ld_we_i;
            if (ld_req_i && !ld_we_i) begin
                ld_rdata_o <= mem[ld_idx_i];
            end
            if (obi.req && ld_req_i && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cnn_obi_mem_sbr.sv
// Directed bench: a Latency=1 instance for data/error/stall checks, a Latency=3 instance for bursts.
module tb_cnn_obi_mem_sbr;
    localparam logic [31:0] Base = 32'h1A10_0000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cnn_obi_mem_sbr_if #(.IdWidth(4)) o1 ();
    cnn_obi_mem_sbr_if #(.IdWidth(4)) o3 ();

    logic        ld1_req, ld1_we, ld1_rvalid;
    logic [9:0]  ld1_idx;
    logic [31:0] ld1_wdata, ld1_rdata;
    logic [15:0] stall1;
    logic        ld3_req, ld3_we, ld3_rvalid;
    logic [9:0]  ld3_idx;
    logic [31:0] ld3_wdata, ld3_rdata;
    logic [15:0] stall3;

    cnn_obi_mem_sbr #(.NumWords(1024), .BaseAddr(Base), .Latency(1), .IdWidth(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .obi(o1),
        .ld_req_i(ld1_req), .ld_we_i(ld1_we), .ld_idx_i(ld1_idx), .ld_wdata_i(ld1_wdata),
        .ld_rdata_o(ld1_rdata), .ld_rvalid_o(ld1_rvalid), .stall_cnt_o(stall1)
    );

    cnn_obi_mem_sbr #(.NumWords(1024), .BaseAddr(Base), .Latency(3), .IdWidth(4)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .obi(o3),
        .ld_req_i(ld3_req), .ld_we_i(ld3_we), .ld_idx_i(ld3_idx), .ld_wdata_i(ld3_wdata),
        .ld_rdata_o(ld3_rdata), .ld_rvalid_o(ld3_rvalid), .stall_cnt_o(stall3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obi1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
        o1.req = req; o1.we = we; o1.addr = addr; o1.be = be; o1.wdata = wdata; o1.aid = aid;
    endtask

    task automatic obi3(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
        o3.req = req; o3.we = we; o3.addr = addr; o3.be = be; o3.wdata = wdata; o3.aid = aid;
    endtask

    task automatic ld1(input logic req, input logic we, input logic [9:0] idx, input logic [31:0] wdata);
        ld1_req = req; ld1_we = we; ld1_idx = idx; ld1_wdata = wdata;
    endtask

    task automatic ld3(input logic req, input logic we, input logic [9:0] idx, input logic [31:0] wdata);
        ld3_req = req; ld3_we = we; ld3_idx = idx; ld3_wdata = wdata;
    endtask

    initial begin
        int pulses;
        int k;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        obi1(0, 0, 0, 0, 0, 0);
        obi3(0, 0, 0, 0, 0, 0);
        ld1(0, 0, 0, 0);
        ld3(0, 0, 0, 0);
        #12;
        chk("rst_rvalid", 32'(o1.rvalid), 0);
        chk("rst_ld_rvalid", 32'(ld1_rvalid), 0);
        chk("rst_stall", 32'(stall1), 0);
        chk("rst_rdata", o1.rdata, 0);
        rst_n = 1'b1;
        tick();

        // Preload: idx3, idx0, idx2, idx1023 on the Latency=1 instance
        ld1(1, 1, 10'd3, 32'h1122_3344);    tick();
        ld1(1, 1, 10'd0, 32'hCAFE_0000);    tick();
        ld1(1, 1, 10'd2, 32'h2222_2222);    tick();
        ld1(1, 1, 10'd1023, 32'h5A5A_0FFC); tick();
        ld1(0, 0, 0, 0);

        // Load write then OBI read of the same word
        obi1(1, 0, Base + 32'h0C, 4'hF, 0, 4'd5);
        #1 chk("rd3_gnt", 32'(o1.gnt), 1);
        tick();
        chk("rd3_rvalid", 32'(o1.rvalid), 1);
        chk("rd3_rdata", o1.rdata, 32'h1122_3344);
        chk("rd3_err", 32'(o1.err), 0);
        chk("rd3_rid", 32'(o1.rid), 5);

        // Byte-enabled write followed immediately by a read of the same word
        obi1(1, 1, Base + 32'h0C, 4'b0101, 32'hAABB_CCDD, 4'd6);
        tick();
        chk("wr_rvalid", 32'(o1.rvalid), 1);
        chk("wr_err", 32'(o1.err), 0);
        chk("wr_rdata", o1.rdata, 0);
        chk("wr_rid", 32'(o1.rid), 6);
        obi1(1, 0, Base + 32'h0C, 4'hF, 0, 4'd7);
        tick();
        chk("rbw_rdata", o1.rdata, 32'h11BB_33DD);
        chk("rbw_rid", 32'(o1.rid), 7);

        // Empty byte-enable write is a no-op
        obi1(1, 1, Base + 32'h0C, 4'b0000, 32'h0, 4'd8);
        tick();
        chk("be0_rvalid", 32'(o1.rvalid), 1);
        obi1(1, 0, Base + 32'h0C, 4'hF, 0, 4'd9);
        tick();
        chk("be0_rdata", o1.rdata, 32'h11BB_33DD);

        // Range boundaries
        obi1(1, 0, Base + 32'h0FFC, 4'hF, 0, 4'd1);
        tick();
        chk("last_err", 32'(o1.err), 0);
        chk("last_rdata", o1.rdata, 32'h5A5A_0FFC);
        obi1(1, 0, Base + 32'h1000, 4'hF, 0, 4'd2);
        tick();
        chk("hi_rvalid", 32'(o1.rvalid), 1);
        chk("hi_err", 32'(o1.err), 1);
        chk("hi_rdata", o1.rdata, 32'hBADC_AB1E);
        obi1(1, 0, 32'h1A0F_FFFC, 4'hF, 0, 4'd3);
        tick();
        chk("lo_err", 32'(o1.err), 1);
        chk("lo_rdata", o1.rdata, 32'hBADC_AB1E);
        chk("lo_rid", 32'(o1.rid), 3);
        obi1(1, 1, Base + 32'h1000, 4'hF, 32'hFFFF_FFFF, 4'd4);
        tick();
        chk("oorw_err", 32'(o1.err), 1);
        chk("oorw_rdata", o1.rdata, 32'hBADC_AB1E);
        obi1(1, 1, 32'h1A0F_FFFC, 4'hF, 32'hFFFF_FFFF, 4'd4);
        tick();
        obi1(0, 0, 0, 0, 0, 0);
        ld1(1, 0, 10'd0, 0);
        tick();
        chk("oor_w0_ldv", 32'(ld1_rvalid), 1);
        chk("oor_w0_data", ld1_rdata, 32'hCAFE_0000);
        ld1(1, 0, 10'd1023, 0);
        tick();
        chk("oor_w1023_data", ld1_rdata, 32'h5A5A_0FFC);
        ld1(0, 0, 0, 0);
        tick();
        chk("ld_rvalid_pulse", 32'(ld1_rvalid), 0);

        // OBI request held against three cycles of load-port reads
        obi1(1, 0, Base + 32'h08, 4'hF, 0, 4'd10);
        for (int c = 0; c < 3; c++) begin
            ld1(1, 0, 10'd3, 0);
            #1 chk("stall_gnt", 32'(o1.gnt), 0);
            tick();
            chk("stall_norsp", 32'(o1.rvalid), 0);
        end
        chk("stall_cnt", 32'(stall1), 3);
        chk("stall_ld_data", ld1_rdata, 32'h11BB_33DD);
        ld1(0, 0, 0, 0);
        #1 chk("stall_regnt", 32'(o1.gnt), 1);
        tick();
        chk("stall_rsp_v", 32'(o1.rvalid), 1);
        chk("stall_rsp_d", o1.rdata, 32'h2222_2222);
        chk("stall_rsp_id", 32'(o1.rid), 10);
        obi1(0, 0, 0, 0, 0, 0);
        tick();
        chk("stall_one_rsp", 32'(o1.rvalid), 0);
        chk("stall_cnt_hold", 32'(stall1), 3);

        // Latency=3 burst of eight reads
        for (int i = 0; i < 8; i++) begin
            ld3(1, 1, 10'(i), 32'h100 + 32'(i));
            tick();
        end
        ld3(0, 0, 0, 0);
        pulses = 0;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) obi3(1, 0, Base + 32'(4 * c), 4'hF, 0, 4'(c));
            else       obi3(0, 0, 0, 0, 0, 0);
            tick();
            k = c - 2;
            if (k >= 0 && k < 8) begin
                chk("burst_rvalid", 32'(o3.rvalid), 1);
                chk("burst_rdata", o3.rdata, 32'h100 + 32'(k));
                chk("burst_rid", 32'(o3.rid), 32'(k));
            end else begin
                chk("burst_idle", 32'(o3.rvalid), 0);
            end
            if (o3.rvalid) pulses++;
        end
        chk("burst_pulses", 32'(pulses), 8);

        // Reset while responses are in flight
        obi3(1, 0, Base, 4'hF, 0, 4'd1);       tick();
        obi3(1, 0, Base + 32'h4, 4'hF, 0, 4'd2); tick();
        obi3(0, 0, 0, 0, 0, 0);
        ld3(1, 0, 10'd0, 0);
        obi1(1, 0, Base + 32'h08, 4'hF, 0, 4'd11);
        tick();
        ld3(0, 0, 0, 0);
        obi1(0, 0, 0, 0, 0, 0);
        chk("pre_rst_rv1", 32'(o1.rvalid), 1);
        chk("pre_rst_rv3", 32'(o3.rvalid), 1);
        chk("pre_rst_ldv3", 32'(ld3_rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rv1", 32'(o1.rvalid), 0);
        chk("mid_rst_rv3", 32'(o3.rvalid), 0);
        chk("mid_rst_ldv3", 32'(ld3_rvalid), 0);
        chk("mid_rst_stall1", 32'(stall1), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_rv3", 32'(o3.rvalid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end
endmodule
